// File: rtl/mem_ctrl_burst_if.sv
// Host-side command/data port of the burst memory controller.
// The controller uses the slave view; the host drives through the master view.
interface mem_ctrl_burst_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              cmd_n;
  logic              RDnWR;
  logic [ADDR_W-1:0] Addr_in;
  logic              Data_in_vld;
  logic [DATA_W-1:0] Data_in;
  logic              ready;
  logic [DATA_W-1:0] Data_out;
  logic              data_out_vld;

  modport slave (
    input  cmd_n, RDnWR, Addr_in, Data_in_vld, Data_in,
    output ready, Data_out, data_out_vld
  );

  modport master (
    output cmd_n, RDnWR, Addr_in, Data_in_vld, Data_in,
    input  ready, Data_out, data_out_vld
  );
endinterface

// File: rtl/mem_ctrl_burst.sv
// Open-row memory controller: single-word host requests become ACT/PRE/WR/RD
// commands with the word moved as a multi-beat burst on a narrow DQ bus.
module mem_ctrl_burst #(
  parameter int DATA_W = 32,
  parameter int DQ_W   = 8,
  parameter int RA_W   = 4,
  parameter int CA_W   = 12,
  parameter int TRCD   = 2,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_ctrl_burst_if.slave     host,
  output logic [2:0]          command,
  output logic [RA_W-1:0]     RA,
  output logic [CA_W-1:0]     CA,
  output logic                cs_n,
  output logic [DQ_W-1:0]     dq_out,
  output logic                dq_oe,
  input  logic [DQ_W-1:0]     dq_in
);
  localparam int BEATS  = DATA_W / DQ_W;
  localparam int ADDR_W = RA_W + CA_W;
  localparam int MAX_AB = (BEATS > TRCD) ? BEATS : TRCD;
  localparam int MAXC   = (MAX_AB > RD_LAT) ? MAX_AB : RD_LAT;
  localparam int CNT_W  = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ACT, S_TRCD_WAIT, S_WR_BURST, S_RD_CMD, S_RD_WAIT, S_RD_BURST
  } state_e;

  typedef enum logic [2:0] {
    CMD_NOP = 3'b000, CMD_ACT = 3'b001, CMD_WR = 3'b010, CMD_RD = 3'b011, CMD_PRE = 3'b100
  } cmd_e;

  state_e            state_q, state_d;
  cmd_e              cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic              row_open_q, row_open_d;
  logic [RA_W-1:0]   open_row_q, open_row_d;
  logic [RA_W-1:0]   ra_q, ra_d;
  logic [CA_W-1:0]   ca_q, ca_d;
  logic              cs_n_q, cs_n_d;
  logic [DQ_W-1:0]   dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic              ready_q, ready_d;
  logic              accept, go_act, go_cmd;

  assign accept = !host.cmd_n && ready_q && (host.RDnWR || host.Data_in_vld);

  always_comb begin
    state_d    = state_q;
    cmd_d      = CMD_NOP;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    row_open_d = row_open_q;
    open_row_d = open_row_q;
    ra_d       = ra_q;
    ca_d       = ca_q;
    dq_out_d   = dq_out_q;
    dq_oe_d    = 1'b0;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    ready_d    = ready_q;
    go_act     = 1'b0;
    go_cmd     = 1'b0;

    case (state_q)
      S_IDLE: if (accept) begin
        addr_d  = host.Addr_in;
        wdata_d = host.Data_in;
        rd_d    = host.RDnWR;
        ready_d = 1'b0;
        if (!row_open_q) begin
          go_act = 1'b1;
        end else if (host.Addr_in[ADDR_W-1 -: RA_W] == open_row_q) begin
          go_cmd = 1'b1;
        end else begin
          state_d    = S_PRE;
          cmd_d      = CMD_PRE;
          row_open_d = 1'b0;
        end
      end
      S_PRE: go_act = 1'b1;
      S_ACT: begin
        if (TRCD == 1) begin
          go_cmd = 1'b1;
        end else begin
          state_d = S_TRCD_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      S_TRCD_WAIT: begin
        if (cnt_q == CNT_W'(TRCD - 1)) go_cmd = 1'b1;
        else                            cnt_d  = cnt_q + CNT_W'(1);
      end
      S_WR_BURST: begin
        if (cnt_q == CNT_W'(BEATS - 1)) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          dq_oe_d  = 1'b1;
          dq_out_d = wdata_q[(int'(cnt_q) + 1) * DQ_W +: DQ_W];
        end
      end
      S_RD_CMD: begin
        if (RD_LAT == 1) begin
          state_d = S_RD_BURST;
          cnt_d   = '0;
        end else begin
          state_d = S_RD_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          state_d = S_RD_BURST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_BURST: begin
        rbuf_d[int'(cnt_q) * DQ_W +: DQ_W] = dq_in;
        if (cnt_q == CNT_W'(BEATS - 1)) begin
          dout_d     = rbuf_d;
          dout_vld_d = 1'b1;
          ready_d    = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // addr_d/wdata_d/rd_d already hold the live request when launched from IDLE
    if (go_act) begin
      state_d    = S_ACT;
      cmd_d      = CMD_ACT;
      ra_d       = addr_d[ADDR_W-1 -: RA_W];
      row_open_d = 1'b1;
      open_row_d = addr_d[ADDR_W-1 -: RA_W];
    end
    if (go_cmd) begin
      ca_d  = addr_d[CA_W-1:0];
      cnt_d = '0;
      if (rd_d) begin
        state_d = S_RD_CMD;
        cmd_d   = CMD_RD;
      end else begin
        state_d  = S_WR_BURST;
        cmd_d    = CMD_WR;
        dq_oe_d  = 1'b1;
        dq_out_d = wdata_d[DQ_W-1:0];
      end
    end
    cs_n_d = (cmd_d == CMD_NOP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_NOP;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      row_open_q <= 1'b0;
      open_row_q <= '0;
      ra_q       <= '0;
      ca_q       <= '0;
      cs_n_q     <= 1'b1;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      row_open_q <= row_open_d;
      open_row_q <= open_row_d;
      ra_q       <= ra_d;
      ca_q       <= ca_d;
      cs_n_q     <= cs_n_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      ready_q    <= ready_d;
    end
  end

  assign command           = cmd_q;
  assign RA                = ra_q;
  assign CA                = ca_q;
  assign cs_n              = cs_n_q;
  assign dq_out            = dq_out_q;
  assign dq_oe             = dq_oe_q;
  assign host.ready        = ready_q;
  assign host.Data_out     = dout_q;
  assign host.data_out_vld = dout_vld_q;
endmodule

// File: tb/tb_mem_ctrl_burst.sv
// Bench for mem_ctrl_burst: the bench plays host and memory, predicting the
// command timeline from the open-row rules and read data from a word store.
module tb_mem_ctrl_burst;
  localparam int DATA_W = 32;
  localparam int DQ_W   = 8;
  localparam int RA_W   = 4;
  localparam int CA_W   = 12;
  localparam int TRCD   = 2;
  localparam int RD_LAT = 2;
  localparam int BEATS  = DATA_W / DQ_W;
  localparam int ADDR_W = RA_W + CA_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) hif ();
  logic [2:0]      command;
  logic [RA_W-1:0] RA;
  logic [CA_W-1:0] CA;
  logic            cs_n;
  logic [DQ_W-1:0] dq_out;
  logic            dq_oe;
  logic [DQ_W-1:0] dq_in;

  mem_ctrl_burst #(
    .DATA_W(DATA_W), .DQ_W(DQ_W), .RA_W(RA_W), .CA_W(CA_W), .TRCD(TRCD), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .host(hif), .command(command), .RA(RA), .CA(CA),
    .cs_n(cs_n), .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
  );

  // Second build: 16-bit DQ, minimum latencies
  mem_ctrl_burst_if #(.DATA_W(32), .ADDR_W(16)) bif ();
  logic [2:0]  b_command;
  logic [3:0]  b_RA;
  logic [11:0] b_CA;
  logic        b_cs_n;
  logic [15:0] b_dq_out;
  logic        b_dq_oe;
  logic [15:0] b_dq_in;

  mem_ctrl_burst #(
    .DATA_W(32), .DQ_W(16), .RA_W(4), .CA_W(12), .TRCD(1), .RD_LAT(1)
  ) dut_b (
    .clk(clk), .rst(rst), .host(bif), .command(b_command), .RA(b_RA), .CA(b_CA),
    .cs_n(b_cs_n), .dq_out(b_dq_out), .dq_oe(b_dq_oe), .dq_in(b_dq_in)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference state: open-row bookkeeping and memory contents
  bit              row_open_m;
  logic [RA_W-1:0] open_row_m;
  logic [31:0]     mem [logic [15:0]];

  task automatic check_reset_outs(input string tag);
    check({tag, ".command"}, command, 3'b000);
    check({tag, ".cs_n"}, cs_n, 1'b1);
    check({tag, ".RA"}, RA, '0);
    check({tag, ".CA"}, CA, '0);
    check({tag, ".dq_out"}, dq_out, '0);
    check({tag, ".dq_oe"}, dq_oe, 1'b0);
    check({tag, ".Data_out"}, hif.Data_out, '0);
    check({tag, ".data_out_vld"}, hif.data_out_vld, 1'b0);
    check({tag, ".ready"}, hif.ready, 1'b1);
  endtask

  // One host request; abort_at>0 asserts reset in that cycle instead of finishing
  task automatic run_req(input bit rd, input logic [15:0] addr, input logic [31:0] wdata,
                         input int abort_at);
    logic [RA_W-1:0] row;
    logic [CA_W-1:0] col;
    logic [31:0]     rword;
    int pre_c, act_c, t_cmd, n_end, b;
    logic [2:0] exp_cmd;
    bit wbeat;
    row   = addr[15:12];
    col   = addr[11:0];
    pre_c = -1;
    act_c = -1;
    if (row_open_m && row == open_row_m) begin
      t_cmd = 1;
    end else if (!row_open_m) begin
      act_c = 1;
      t_cmd = 1 + TRCD;
    end else begin
      pre_c = 1;
      act_c = 2;
      t_cmd = 2 + TRCD;
    end
    n_end = rd ? t_cmd + RD_LAT + BEATS : t_cmd + BEATS;
    if (rd && !mem.exists(addr)) mem[addr] = $urandom;
    rword = rd ? mem[addr] : 32'h0;

    @(negedge clk);
    hif.cmd_n       = 1'b0;
    hif.RDnWR       = rd;
    hif.Addr_in     = addr;
    hif.Data_in_vld = rd ? 1'($urandom) : 1'b1;
    hif.Data_in     = wdata;
    @(posedge clk);
    for (int n = 1; n <= n_end; n++) begin
      @(negedge clk);
      if (n == abort_at) begin
        rst = 1'b1;
        hif.cmd_n = 1'b1;
        #1;
        check_reset_outs("abort");
        @(negedge clk);
        rst = 1'b0;
        row_open_m = 1'b0;
        return;
      end
      exp_cmd = (n == pre_c) ? 3'b100 : (n == act_c) ? 3'b001 :
                (n == t_cmd) ? (rd ? 3'b011 : 3'b010) : 3'b000;
      check("command", command, exp_cmd);
      check("cs_n", cs_n, exp_cmd == 3'b000);
      if (n == act_c) check("RA", RA, row);
      if (n == t_cmd) check("CA", CA, col);
      wbeat = !rd && n >= t_cmd && n < t_cmd + BEATS;
      check("dq_oe", dq_oe, wbeat);
      if (wbeat) check("dq_out", dq_out, wdata[(n - t_cmd) * DQ_W +: DQ_W]);
      check("ready", hif.ready, n == n_end);
      check("data_out_vld", hif.data_out_vld, rd && n == n_end);
      if (rd && n == n_end) check("Data_out", hif.Data_out, rword);
      b = n - (t_cmd + RD_LAT);
      dq_in = (rd && b >= 0 && b < BEATS) ? rword[b * DQ_W +: DQ_W] : DQ_W'($urandom);
      if (n < n_end) begin
        hif.cmd_n       = 1'($urandom);
        hif.RDnWR       = 1'($urandom);
        hif.Addr_in     = 16'($urandom);
        hif.Data_in_vld = 1'($urandom);
        hif.Data_in     = $urandom;
      end else begin
        hif.cmd_n = 1'b1;
      end
    end
    if (act_c > 0) begin
      row_open_m = 1'b1;
      open_row_m = row;
    end
    if (!rd) mem[addr] = wdata;
  endtask

  task automatic bad_strobe();
    @(negedge clk);
    hif.cmd_n       = 1'b0;
    hif.RDnWR       = 1'b0;
    hif.Data_in_vld = 1'b0;
    hif.Addr_in     = 16'($urandom);
    hif.Data_in     = $urandom;
    @(negedge clk);
    hif.cmd_n = 1'b1;
    check("novld.command", command, 3'b000);
    check("novld.ready", hif.ready, 1'b1);
  endtask

  task automatic run_b();
    logic [2:0] exp_cmd;
    @(negedge clk);
    bif.cmd_n   = 1'b0;
    bif.RDnWR   = 1'b1;
    bif.Addr_in = 16'h7123;
    @(posedge clk);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      bif.cmd_n = 1'b1;
      exp_cmd = (n == 1) ? 3'b001 : (n == 2) ? 3'b011 : 3'b000;
      check("b.command", b_command, exp_cmd);
      if (n == 1) check("b.RA", b_RA, 4'h7);
      if (n == 2) check("b.CA", b_CA, 12'h123);
      check("b.dq_oe", b_dq_oe, 1'b0);
      check("b.data_out_vld", bif.data_out_vld, n == 5);
      check("b.ready", bif.ready, n == 5);
      if (n == 5) check("b.Data_out", bif.Data_out, 32'hCAFEBEEF);
      b_dq_in = (n == 3) ? 16'hBEEF : (n == 4) ? 16'hCAFE : 16'($urandom);
    end
  endtask

  initial begin
    bit rd;
    logic [15:0] addr;
    int abort;
    hif.cmd_n = 1'b1; hif.RDnWR = 1'b0; hif.Addr_in = '0; hif.Data_in_vld = 1'b0; hif.Data_in = '0;
    bif.cmd_n = 1'b1; bif.RDnWR = 1'b0; bif.Addr_in = '0; bif.Data_in_vld = 1'b0; bif.Data_in = '0;
    dq_in = '0;
    b_dq_in = '0;
    row_open_m = 1'b0;
    open_row_m = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;

    mem[16'h3010] = 32'h44332211;
    run_req(1'b0, 16'h30A5, 32'hDEADBEEF, 0);
    run_req(1'b1, 16'h3010, 32'h0, 0);
    run_req(1'b0, 16'h5000, 32'h01234567, 0);
    run_req(1'b1, 16'h5000, 32'h0, 0);
    bad_strobe();
    run_req(1'b0, 16'h3111, 32'hA5A5_5A5A, 2 + TRCD + 2);
    run_req(1'b0, 16'h3222, 32'h600D_F00D, 0);
    run_b();

    for (int i = 0; i < 40; i++) begin
      rd    = 1'($urandom);
      addr  = {4'($urandom_range(0, 3)), 12'($urandom_range(0, 7))};
      abort = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 0;
      if ($urandom_range(0, 5) == 0) bad_strobe();
      run_req(rd, addr, $urandom, abort);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
